// File: rtl/spatial_filter_pkg.sv
// Shared definitions for the spatial filter datapath.
//   KERNEL_TAPS / KERNEL_DIM : 3x3 kernel geometry
//   PIXEL_SIZE_DEFAULT       : default pixel width, must match the convolution stage
//   win_idx(r, c)            : packed window element index, top-left = 0, current pixel = 8
package spatial_filter_pkg;

  localparam int unsigned KERNEL_TAPS        = 9;
  localparam int unsigned KERNEL_DIM         = 3;
  localparam int unsigned PIXEL_SIZE_DEFAULT = 32;

  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return KERNEL_DIM * r + c;
  endfunction

endpackage

// File: rtl/window_generator_if.sv
// Pixel-stream in / 3x3-window-stream out bundle for window_generator.
//   i_pixel_data, i_pixel_data_valid, i_sof : raster-order input stream (no backpressure)
//   o_pixel_data, o_pixel_data_valid        : packed 3x3 window and its strobe
//   o_window_last                           : only when WINDOW_GEN_LAST_EN is defined
// Modports: master = stream source / window sink, slave = window generator.
interface window_generator_if
  import spatial_filter_pkg::*;
#(
  parameter int unsigned PIXEL_SIZE = PIXEL_SIZE_DEFAULT
) ();

  logic [PIXEL_SIZE-1:0]             i_pixel_data;
  logic                              i_pixel_data_valid;
  logic                              i_sof;
  logic [PIXEL_SIZE*KERNEL_TAPS-1:0] o_pixel_data;
  logic                              o_pixel_data_valid;
`ifdef WINDOW_GEN_LAST_EN
  logic                              o_window_last;
`endif

  modport master (
    output i_pixel_data, i_pixel_data_valid, i_sof,
`ifdef WINDOW_GEN_LAST_EN
    input  o_window_last,
`endif
    input  o_pixel_data, o_pixel_data_valid
  );

  modport slave (
    input  i_pixel_data, i_pixel_data_valid, i_sof,
`ifdef WINDOW_GEN_LAST_EN
    output o_window_last,
`endif
    output o_pixel_data, o_pixel_data_valid
  );

endinterface

// File: rtl/line_buffer.sv
// Single-port register-file line buffer.
//   clk_i   : write clock
//   we_i    : write enable
//   addr_i  : shared read/write address
//   wdata_i : write data
//   rdata_o : asynchronous read; returns the value stored before a same-cycle write
// Contents are never cleared.
module line_buffer #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_generator.sv
// Streaming 3x3 window generator.
//   clk   : single clock
//   reset : synchronous active-high reset
//   bus   : window_generator_if.slave (pixel stream in, packed window out)
// Window element k = 3*r + c sits at bits [k*PIXEL_SIZE +: PIXEL_SIZE]; r = 0 is the oldest
// line, c = 0 the oldest column, k = 8 the pixel just accepted. Latency is one clock.
// Optional feature macro: WINDOW_GEN_LAST_EN adds o_window_last for the bottom-right window.
module window_generator
  import spatial_filter_pkg::*;
#(
  parameter int unsigned PIXEL_SIZE = PIXEL_SIZE_DEFAULT,
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512
) (
  input logic               clk,
  input logic               reset,
  window_generator_if.slave bus
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);
  localparam int unsigned WinW = PIXEL_SIZE * KERNEL_TAPS;

  logic                  pix_valid;
  logic                  accept;
  logic [ColW-1:0]       col_q, col_d, pos_col;
  logic [RowW-1:0]       row_q, row_d, pos_row;
  logic [PIXEL_SIZE-1:0] lb1_rd, lb2_rd;
  logic [PIXEL_SIZE-1:0] col_in [KERNEL_DIM];
  logic [PIXEL_SIZE-1:0] sr_q   [KERNEL_DIM][KERNEL_DIM];
  logic [PIXEL_SIZE-1:0] sr_d   [KERNEL_DIM][KERNEL_DIM];
  logic [WinW-1:0]       win_q, win_d;
  logic                  valid_q, valid_d;
  logic                  win_hit;

  assign pix_valid = bus.i_pixel_data_valid;
  // Reset wins over a coincident pixel, so the line buffers must not see it either.
  assign accept    = pix_valid & ~reset;

  // A start-of-frame pixel is position (0,0) regardless of where the counters are.
  assign pos_col = bus.i_sof ? '0 : col_q;
  assign pos_row = bus.i_sof ? '0 : row_q;

  assign win_hit = pix_valid && (pos_row >= RowW'(2)) && (pos_col >= ColW'(2));

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_SIZE)
  ) u_lb1 (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (pos_col),
    .wdata_i (bus.i_pixel_data),
    .rdata_o (lb1_rd)
  );

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_SIZE)
  ) u_lb2 (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (pos_col),
    .wdata_i (lb1_rd),
    .rdata_o (lb2_rd)
  );

  assign col_in[0] = lb2_rd;
  assign col_in[1] = lb1_rd;
  assign col_in[2] = bus.i_pixel_data;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (pos_col == ColW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (pos_row == RowW'(IMG_HEIGHT - 1)) ? '0 : pos_row + RowW'(1);
      end else begin
        col_d = pos_col + ColW'(1);
        row_d = pos_row;
      end
    end
  end

  always_comb begin
    sr_d    = sr_q;
    win_d   = win_q;
    valid_d = 1'b0;
    if (pix_valid) begin
      for (int unsigned r = 0; r < KERNEL_DIM; r++) begin
        for (int unsigned c = 0; c < KERNEL_DIM - 1; c++) begin
          sr_d[r][c] = sr_q[r][c+1];
        end
        sr_d[r][KERNEL_DIM-1] = col_in[r];
      end
    end
    // Window data only moves when a window is emitted, so it holds across gaps.
    if (win_hit) begin
      valid_d = 1'b1;
      for (int unsigned r = 0; r < KERNEL_DIM; r++) begin
        for (int unsigned c = 0; c < KERNEL_DIM; c++) begin
          win_d[win_idx(r, c)*PIXEL_SIZE +: PIXEL_SIZE] = sr_d[r][c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      for (int unsigned r = 0; r < KERNEL_DIM; r++) begin
        for (int unsigned c = 0; c < KERNEL_DIM; c++) begin
          sr_q[r][c] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      sr_q    <= sr_d;
    end
  end

  assign bus.o_pixel_data       = win_q;
  assign bus.o_pixel_data_valid = valid_q;

`ifdef WINDOW_GEN_LAST_EN
  logic last_q, last_d;

  assign last_d = win_hit && (pos_row == RowW'(IMG_HEIGHT - 1))
                          && (pos_col == ColW'(IMG_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

  assign bus.o_window_last = last_q;
`endif

endmodule

// File: tb/tb_window_generator.sv
module tb_window_generator;

  localparam int unsigned P    = 32;
  localparam int          W    = 4;
  localparam int          H    = 4;
  localparam int unsigned WinW = P * 9;

  typedef struct packed {
    logic [WinW-1:0] data;
    logic            last;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  window_generator_if #(.PIXEL_SIZE(P)) bus_if ();

  window_generator #(
    .PIXEL_SIZE (P),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial forever #5 clk = ~clk;

  int              total = 0;
  int              bad   = 0;
  exp_t            exp_q[$];
  logic [P-1:0]    img [H][W];
  int              mr = 0;
  int              mc = 0;
  bit              exp_valid_next = 1'b0;
  bit              exp_valid_q    = 1'b0;
  bit              rst_applied_q  = 1'b0;
  logic [WinW-1:0] last_win = '0;

  task automatic chk_win(input string name, input logic [WinW-1:0] act,
                         input logic [WinW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  // Reference model: the frame is a 2-D image indexed by (row, col); a window is simply the
  // 3x3 block of the image ending at the pixel just received.
  task automatic apply(input bit rst, input bit v, input logic [P-1:0] pix, input bit sof);
    exp_t e;
    @(posedge clk);
    #1;
    reset                     = rst;
    bus_if.i_pixel_data_valid = v;
    bus_if.i_pixel_data       = pix;
    bus_if.i_sof              = sof;
    exp_valid_next            = 1'b0;
    if (rst) begin
      mr = 0;
      mc = 0;
    end else if (v) begin
      if (sof) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = pix;
      if (mr >= 2 && mc >= 2) begin
        e = '0;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            e.data[(3*r+c)*P +: P] = img[mr-2+r][mc-2+c];
          end
        end
        e.last = (mr == H - 1) && (mc == W - 1);
        exp_q.push_back(e);
        exp_valid_next = 1'b1;
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    exp_valid_q   <= exp_valid_next;
    rst_applied_q <= reset;
  end

  always @(negedge clk) begin : monitor
    exp_t me;
    chk_bit("valid", bus_if.o_pixel_data_valid, exp_valid_q);
    if (rst_applied_q) begin
      chk_win("reset_data", bus_if.o_pixel_data, '0);
      last_win = '0;
    end else if (bus_if.o_pixel_data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_window: got %h want none", bus_if.o_pixel_data);
      end else begin
        me = exp_q.pop_front();
        chk_win("window", bus_if.o_pixel_data, me.data);
`ifdef WINDOW_GEN_LAST_EN
        chk_bit("window_last", bus_if.o_window_last, me.last);
`endif
        last_win = me.data;
      end
    end else begin
      chk_win("hold", bus_if.o_pixel_data, last_win);
    end
`ifdef WINDOW_GEN_LAST_EN
    if (bus_if.o_pixel_data_valid !== 1'b1) chk_bit("last_idle", bus_if.o_window_last, 1'b0);
`endif
  end

  initial begin
    bus_if.i_pixel_data_valid = 1'b0;
    bus_if.i_pixel_data       = '0;
    bus_if.i_sof              = 1'b0;

    repeat (3) apply(1'b1, 1'b0, '0, 1'b0);
    apply(1'b0, 1'b0, '0, 1'b0);

    // Continuous 4x4 frame 0..15.
    for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, P'(i), i == 0);
    repeat (2) apply(1'b0, 1'b0, '0, 1'b0);

    // Same frame with gaps; input data changes during gaps and must be ignored.
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b1, P'(i), i == 0);
      apply(1'b0, 1'b0, P'($urandom), 1'b0);
    end

    // Reset mid-frame after pixel 9, then 100..115 without sof.
    for (int i = 0; i < 10; i++) apply(1'b0, 1'b1, P'(i), i == 0);
    apply(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, P'(100 + i), 1'b0);

    // Mid-frame restart: sof on pixel 6.
    for (int i = 0; i < 6; i++) apply(1'b0, 1'b1, P'(200 + i), i == 0);
    for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, P'(300 + i), i == 0);

    // Two back-to-back frames, only the first carries sof.
    for (int i = 0; i < 32; i++) apply(1'b0, 1'b1, P'(400 + i), i == 0);

    // Reset coincident with a valid pixel drops the pixel.
    for (int i = 0; i < 9; i++) apply(1'b0, 1'b1, P'(500 + i), i == 0);
    apply(1'b1, 1'b1, P'(999), 1'b0);
    for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, P'(600 + i), 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(199) == 0, $urandom_range(9) < 7, P'($urandom),
            $urandom_range(39) == 0);
    end

    repeat (4) apply(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
